// File: rtl/cpu_bus_router.sv
// CPU-side request/ack router: decodes address[31:28] onto NUM_DEVICES device channels,
// completing unmapped or unanswered accesses itself and flagging them through sticky errors.
module cpu_bus_router #(
    parameter int NUM_DEVICES    = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cpu_request,
    input  logic [31:0]               cpu_address,
    input  logic [31:0]               cpu_wdata,
    input  logic [3:0]                cpu_wmask,
    output logic                      cpu_ack,
    output logic [31:0]               cpu_rdata,
    output logic [NUM_DEVICES-1:0]    dev_request,
    output logic [31:0]               dev_address,
    output logic [31:0]               dev_wdata,
    output logic [3:0]                dev_wmask,
    input  logic [NUM_DEVICES-1:0]    dev_ack,
    input  logic [32*NUM_DEVICES-1:0] dev_rdata,
    input  logic                      err_clear,
    output logic                      err_unmapped,
    output logic                      err_timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [4:0] NUM_DEV = 5'(NUM_DEVICES);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT     = 2'd1,
        S_UNMAPPED = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [3:0]               idx_q, idx_d;
    logic                     cpu_ack_q, cpu_ack_d;
    logic [31:0]              cpu_rdata_q, cpu_rdata_d;
    logic [NUM_DEVICES-1:0]   dev_request_q, dev_request_d;
    logic [31:0]              dev_address_q, dev_address_d;
    logic [31:0]              dev_wdata_q, dev_wdata_d;
    logic [3:0]               dev_wmask_q, dev_wmask_d;
    logic                     err_un_q, err_un_d;
    logic                     err_to_q, err_to_d;

    logic [3:0]               req_idx_s;
    logic                     mapped_s;
    logic [15:0]              onehot_s;
    logic [15:0]              ack_pad_s;
    logic [32*16-1:0]         rdata_pad_s;
    logic                     sel_ack_s;
    logic [31:0]              sel_rdata_s;
    logic                     set_un_s;
    logic                     set_to_s;

    // Channels are padded to the full 16-entry decode space so any 4-bit index selects safely.
    assign req_idx_s   = cpu_address[31:28];
    assign mapped_s    = ({1'b0, req_idx_s} < NUM_DEV);
    assign onehot_s    = 16'd1 << req_idx_s;
    assign ack_pad_s   = 16'(dev_ack);
    assign rdata_pad_s = (32*16)'(dev_rdata);
    assign sel_ack_s   = ack_pad_s[idx_q];
    assign sel_rdata_s = rdata_pad_s[{idx_q, 5'd0} +: 32];

    // Next-state and output logic of the transaction FSM.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        cpu_ack_d     = 1'b0;
        cpu_rdata_d   = cpu_rdata_q;
        dev_request_d = '0;
        dev_address_d = dev_address_q;
        dev_wdata_d   = dev_wdata_q;
        dev_wmask_d   = dev_wmask_q;
        set_un_s      = 1'b0;
        set_to_s      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_request) begin
                    dev_address_d = cpu_address;
                    dev_wdata_d   = cpu_wdata;
                    dev_wmask_d   = cpu_wmask;
                    idx_d         = req_idx_s;
                    cnt_d         = '0;
                    if (mapped_s) begin
                        dev_request_d = onehot_s[NUM_DEVICES-1:0];
                        state_d       = S_WAIT;
                    end else begin
                        state_d       = S_UNMAPPED;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_UNMAPPED: begin
                cpu_ack_d   = 1'b1;
                cpu_rdata_d = 32'h0000_0000;
                set_un_s    = 1'b1;
                state_d     = S_IDLE;
            end
            S_WAIT: begin
                // A selected ack in the deadline cycle still wins over the timeout.
                if (sel_ack_s) begin
                    cpu_ack_d   = 1'b1;
                    cpu_rdata_d = sel_rdata_s;
                    state_d     = S_IDLE;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    cpu_ack_d   = 1'b1;
                    cpu_rdata_d = 32'h0000_0000;
                    set_to_s    = 1'b1;
                    state_d     = S_IDLE;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (set_un_s) begin
            err_un_d = 1'b1;
        end else if (err_clear) begin
            err_un_d = 1'b0;
        end else begin
            err_un_d = err_un_q;
        end

        if (set_to_s) begin
            err_to_d = 1'b1;
        end else if (err_clear) begin
            err_to_d = 1'b0;
        end else begin
            err_to_d = err_to_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            idx_q         <= 4'd0;
            cpu_ack_q     <= 1'b0;
            cpu_rdata_q   <= 32'h0000_0000;
            dev_request_q <= '0;
            dev_address_q <= 32'h0000_0000;
            dev_wdata_q   <= 32'h0000_0000;
            dev_wmask_q   <= 4'h0;
            err_un_q      <= 1'b0;
            err_to_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            cpu_ack_q     <= cpu_ack_d;
            cpu_rdata_q   <= cpu_rdata_d;
            dev_request_q <= dev_request_d;
            dev_address_q <= dev_address_d;
            dev_wdata_q   <= dev_wdata_d;
            dev_wmask_q   <= dev_wmask_d;
            err_un_q      <= err_un_d;
            err_to_q      <= err_to_d;
        end
    end

    assign cpu_ack      = cpu_ack_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign dev_request  = dev_request_q;
    assign dev_address  = dev_address_q;
    assign dev_wdata    = dev_wdata_q;
    assign dev_wmask    = dev_wmask_q;
    assign err_unmapped = err_un_q;
    assign err_timeout  = err_to_q;

endmodule

// File: tb/tb_cpu_bus_router.sv
// Randomized scoreboard bench for cpu_bus_router: the driver pushes expected device requests and
// CPU completions derived from the transaction outcome; a negedge monitor pops and compares.
module tb_cpu_bus_router;

    localparam int ND = 4;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_request;
    logic [31:0]       cpu_address;
    logic [31:0]       cpu_wdata;
    logic [3:0]        cpu_wmask;
    logic              cpu_ack;
    logic [31:0]       cpu_rdata;
    logic [ND-1:0]     dev_request;
    logic [31:0]       dev_address;
    logic [31:0]       dev_wdata;
    logic [3:0]        dev_wmask;
    logic [ND-1:0]     dev_ack;
    logic [32*ND-1:0]  dev_rdata;
    logic              err_clear;
    logic              err_unmapped;
    logic              err_timeout;

    cpu_bus_router #(.NUM_DEVICES(ND), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .cpu_request(cpu_request), .cpu_address(cpu_address),
        .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dev_request(dev_request), .dev_address(dev_address), .dev_wdata(dev_wdata),
        .dev_wmask(dev_wmask), .dev_ack(dev_ack), .dev_rdata(dev_rdata), .err_clear(err_clear),
        .err_unmapped(err_unmapped), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        un;
        logic        to;
        int          cyc;
    } ack_exp_t;

    typedef struct {
        logic [ND-1:0] req;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [3:0]    wmask;
        int            cyc;
    } req_exp_t;

    ack_exp_t aq[$];
    req_exp_t dq[$];

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic m_un = 1'b0;
    logic m_to = 1'b0;
    bit   chk_zero = 1'b0;
    bit   chk_flags = 1'b0;
    bit   final_chk = 1'b0;
    logic [31:0] last_rdata = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: compares DUT outputs against the queued expectations away from the active edge.
    always @(negedge clk) begin
        ack_exp_t ae;
        req_exp_t re;
        if (reset) begin
            last_rdata = 32'h0;
        end else begin
            if (cpu_ack) begin
                if (aq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_cpu_ack: got rdata %0h expected no ack (cycle %0d)", cpu_rdata, cyc);
                end else begin
                    ae = aq.pop_front();
                    chk("ack_cycle", 128'(cyc), 128'(ae.cyc));
                    chk("ack_rdata", 128'(cpu_rdata), 128'(ae.rdata));
                    chk("ack_err_unmapped", 128'(err_unmapped), 128'(ae.un));
                    chk("ack_err_timeout", 128'(err_timeout), 128'(ae.to));
                    last_rdata = ae.rdata;
                end
            end else begin
                chk("rdata_hold", 128'(cpu_rdata), 128'(last_rdata));
            end
            if (dev_request != '0) begin
                if (dq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_dev_request: got %0h expected none (cycle %0d)", dev_request, cyc);
                end else begin
                    re = dq.pop_front();
                    chk("dev_request_cycle", 128'(cyc), 128'(re.cyc));
                    chk("dev_request", 128'(dev_request), 128'(re.req));
                    chk("dev_address", 128'(dev_address), 128'(re.addr));
                    chk("dev_wdata", 128'(dev_wdata), 128'(re.wdata));
                    chk("dev_wmask", 128'(dev_wmask), 128'(re.wmask));
                end
            end
            if (chk_zero) begin
                chk("outputs_zero", 128'({cpu_ack, cpu_rdata, dev_request, dev_address, dev_wdata,
                                          dev_wmask, err_unmapped, err_timeout}), 128'(0));
            end
            if (chk_flags) begin
                chk("flags", 128'({err_unmapped, err_timeout}), 128'({m_un, m_to}));
            end
            if (final_chk) begin
                chk("pending_acks", 128'(aq.size()), 128'(0));
                chk("pending_dev_requests", 128'(dq.size()), 128'(0));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_flags();
        step();
        err_clear = 1'b1;
        m_un = 1'b0;
        m_to = 1'b0;
        step();
        err_clear = 1'b0;
        chk_flags = 1'b1;
        step();
        chk_flags = 1'b0;
    endtask

    // One CPU transaction; the device acks its channel in cycle k (k > TO means never in time).
    task automatic do_txn(input logic [31:0] addr, input logic [31:0] slice_val, input logic [3:0] wmask,
                          input int k, input bit strays, input bit clr_done);
        int ch, d, n_end, edge0;
        bit mapped, got;
        logic [ND-1:0] sel;
        logic [31:0] wd;
        ch     = int'(addr[31:28]);
        mapped = (ch < ND);
        sel    = mapped ? ND'(1 << ch) : '0;
        wd     = $urandom;
        for (int i = 0; i < ND; i++) dev_rdata[i*32 +: 32] = $urandom;
        if (mapped) dev_rdata[ch*32 +: 32] = slice_val;
        got   = mapped && (k <= TO);
        d     = !mapped ? 1 : (got ? k : TO);
        n_end = (mapped && k > d) ? k : d;
        if (!mapped) begin
            m_un = 1'b1;
            if (clr_done) m_to = 1'b0;
        end else if (got) begin
            if (clr_done) begin
                m_un = 1'b0;
                m_to = 1'b0;
            end
        end else begin
            m_to = 1'b1;
            if (clr_done) m_un = 1'b0;
        end
        edge0 = cyc + 1;
        aq.push_back('{rdata: (got ? slice_val : 32'h0), un: m_un, to: m_to, cyc: edge0 + d});
        if (mapped) dq.push_back('{req: sel, addr: addr, wdata: wd, wmask: wmask, cyc: edge0});
        cpu_address = addr;
        cpu_wdata   = wd;
        cpu_wmask   = wmask;
        cpu_request = 1'b1;
        for (int n = 1; n <= n_end; n++) begin
            step();
            cpu_request = 1'b0;
            dev_ack     = strays ? (ND'($urandom) & ~sel) : '0;
            if (mapped && n == k) dev_ack = dev_ack | sel;
            err_clear   = clr_done && (n == d);
            if (strays && n <= d && $urandom_range(0, 3) == 0) cpu_request = 1'b1;
        end
        step();
        cpu_request = 1'b0;
        dev_ack     = '0;
        err_clear   = 1'b0;
        step();
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  wm;
        reset       = 1'b1;
        cpu_request = 1'b0;
        cpu_address = 32'h0;
        cpu_wdata   = 32'h0;
        cpu_wmask   = 4'h0;
        dev_ack     = '0;
        dev_rdata   = '0;
        err_clear   = 1'b0;
        repeat (2) step();
        reset    = 1'b0;
        chk_zero = 1'b1;
        repeat (2) step();
        chk_zero = 1'b0;

        do_txn(32'h2000_0010, 32'hDEAD_BEEF, 4'h0, 3, 1'b0, 1'b0);
        do_txn(32'h9000_0000, 32'h1234_5678, 4'h0, 1, 1'b0, 1'b0);
        clear_flags();
        do_txn(32'h1000_0100, 32'hCAFE_F00D, 4'h0, TO + 1, 1'b0, 1'b0);
        do_txn(32'h1000_0104, 32'h0BAD_CAFE, 4'hF, TO, 1'b0, 1'b0);
        do_txn(32'h1000_0200, 32'hA5A5_5A5A, 4'h0, 5, 1'b1, 1'b0);

        // Reset in cycle 2 of a channel-0 access, then a late ack that must be ignored.
        dq.push_back('{req: ND'(1), addr: 32'h0000_0040, wdata: 32'h7777_0000, wmask: 4'h3, cyc: cyc + 1});
        cpu_address = 32'h0000_0040;
        cpu_wdata   = 32'h7777_0000;
        cpu_wmask   = 4'h3;
        cpu_request = 1'b1;
        step();
        cpu_request = 1'b0;
        step();
        reset = 1'b1;
        m_un  = 1'b0;
        m_to  = 1'b0;
        step();
        reset    = 1'b0;
        chk_zero = 1'b1;
        step();
        dev_ack = ND'(1);
        step();
        dev_ack = '0;
        repeat (2) step();
        chk_zero = 1'b0;
        do_txn(32'h0000_0080, 32'h1357_9BDF, 4'h0, 2, 1'b0, 1'b0);

        do_txn(32'h3000_0000, 32'h2468_ACE0, 4'h0, TO + 2, 1'b0, 1'b1);
        chk_flags = 1'b1;
        step();
        chk_flags = 1'b0;

        for (int t = 0; t < 80; t++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[31:28] = 4'($urandom_range(0, ND - 1));
            wm = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            do_txn(a, $urandom, wm, $urandom_range(1, TO + 2), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 7) == 0) clear_flags();
        end

        clear_flags();
        final_chk = 1'b1;
        step();
        final_chk = 1'b0;
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_bus_router.md
# cpu_bus_router

- Parametrised successor to the single-target CPU bus glue.
- Takes one CPU-side request/ack transaction stream and routes it to one of NUM_DEVICES downstream device channels, decoding on address bits [31:28].
- Adds a per-transaction ack timeout and unmapped-address handling, so a bad access completes instead of hanging the CPU. Both conditions are reported through sticky error flags.
- Sits between the CPU core wrapper and the peripheral/memory devices.

## Interface

Parameters:
- NUM_DEVICES, default 4: number of device channels, legal range 1..16. Channel i serves address[31:28] == i.
- TIMEOUT_CYCLES, default 255: number of wait cycles before a forced completion, legal range 0..65535. A value of 0 disables the timeout.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_request  in  1  one-cycle pulse that starts a transaction.
- cpu_address  in  32  byte address; held stable until cpu_ack.
- cpu_wdata  in  32  write data; held stable until cpu_ack.
- cpu_wmask  in  4  byte write strobes; 0 means read.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  read data, valid while cpu_ack is high.
- dev_request  out  NUM_DEVICES  one-hot, one-cycle request pulse.
- dev_address  out  32  registered copy of cpu_address.
- dev_wdata  out  32  registered copy of cpu_wdata.
- dev_wmask  out  4  registered copy of cpu_wmask.
- dev_ack  in  NUM_DEVICES  per-channel completion pulse.
- dev_rdata  in  32*NUM_DEVICES  per-channel read data; channel i uses bits [32*i+31:32*i].
- err_clear  in  1  clears both sticky error flags.
- err_unmapped  out  1  sticky: an access was made to an index >= NUM_DEVICES.
- err_timeout  out  1  sticky: a transaction was force-completed by the timeout.

## Operation

States: S_IDLE, S_WAIT, S_UNMAPPED.

S_IDLE:
- On cpu_request, latch address, wdata, wmask and the channel index (address[31:28]) into the dev_* registers.
- If index < NUM_DEVICES: pulse dev_request[index] on the next cycle, clear the timeout counter, go to S_WAIT.
- Otherwise: go to S_UNMAPPED; no dev_request is issued.

S_UNMAPPED:
- Pulse cpu_ack with cpu_rdata = 32'h0000_0000.
- Set err_unmapped.
- Return to S_IDLE.

S_WAIT:
- Only dev_ack[index] is honoured; acks on other channels are ignored.
- On the selected ack: capture the matching dev_rdata slice, pulse cpu_ack on the next cycle with that data, return to S_IDLE.
- Otherwise the counter increments. If the counter equals TIMEOUT_CYCLES-1 and no selected ack is sampled that cycle (TIMEOUT_CYCLES != 0):
  - pulse cpu_ack with cpu_rdata = 0 on the next cycle;
  - set err_timeout;
  - return to S_IDLE.
- If the selected ack and the timeout occur in the same cycle, the ack wins: return real data and leave err_timeout unchanged.

Other rules:
- Writes (wmask != 0) still return the captured slice on cpu_rdata. The CPU ignores it.
- cpu_request outside S_IDLE is a protocol violation and is ignored: no state change, no latch.
- dev_ack in S_IDLE or S_UNMAPPED is ignored.
- Sticky flags: err_clear clears both. If err_clear and a set event occur in the same cycle, the set wins.
- Counter width is max(1, $clog2(TIMEOUT_CYCLES+1)). It never wraps, because the transaction ends at TIMEOUT_CYCLES-1.
- cpu_rdata holds its last value outside the cpu_ack cycle.

## Timing

- Reset values: state S_IDLE; counter 0; all outputs 0 (cpu_ack, cpu_rdata, dev_request, dev_address, dev_wdata, dev_wmask, err_unmapped, err_timeout).
- Reset asserted mid-transaction: abort immediately (asynchronous). No cpu_ack is produced, and a dev_ack arriving after reset is released is ignored.
- Cycle numbering: cpu_request is sampled at edge 0.
- Mapped access:
  - dev_request is high in cycle 1, which is also the first S_WAIT cycle, with counter = 0.
  - A selected dev_ack sampled in cycle k (k >= 1) gives cpu_ack in cycle k+1.
  - Minimum latency from cpu_request to cpu_ack is 2 cycles.
- Unmapped access: cpu_ack and err_unmapped both rise in cycle 2.
- Timeout: counter is TIMEOUT_CYCLES-1 in cycle TIMEOUT_CYCLES; cpu_ack and err_timeout rise in cycle TIMEOUT_CYCLES+1.
- Back-to-back: a new cpu_request is accepted in the cycle after cpu_ack.

## Test plan

1. Mapped read: NUM_DEVICES=4. Request address 0x2000_0010, wmask 0. dev_ack[2] in cycle 3 with slice 2 = 0xDEAD_BEEF → dev_request = 4'b0100 in cycle 1, dev_address = 0x2000_0010, cpu_ack in cycle 4 with 0xDEAD_BEEF, no error flags.
2. Unmapped access: request address 0x9000_0000 with NUM_DEVICES=4 → no dev_request, cpu_ack and err_unmapped in cycle 2, cpu_rdata = 0. err_clear then drops err_unmapped.
3. Timeout and deadline: TIMEOUT_CYCLES=8.
   - No ack → cpu_ack in cycle 9 with rdata 0 and err_timeout = 1.
   - Repeat with dev_ack in cycle 8 → real data in cycle 9, err_timeout unchanged.
4. Stray acks: while waiting on channel 1, pulse dev_ack[0] and dev_ack[3] → ignored. dev_ack[1] still completes the transaction. A stray ack and a cpu_request issued in S_WAIT produce no effect.
5. Reset mid-transaction: assert reset in cycle 2 of a channel-0 access, release, then pulse dev_ack[0] → no cpu_ack; all outputs stay 0. A following request completes normally.
6. Set/clear collision: assert err_clear in the same cycle err_timeout is set → err_timeout = 1 afterwards.
